// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central hazard and control-flow sequencer for the 5-stage RV32I pipeline.
// It sits beside EX and uses these inputs:
//   - the resolved branch/jump decision,
//   - ID/EX register-use information,
//   - the data-memory busy flag.
// From them it produces:
//   - the stall and flush controls,
//   - the PC redirect,
//   - a misaligned-target exception flag.
// A post-redirect flush counter covers instruction-memory latency.
// Saturating performance counters count branches and taken branches.
//
// Parameters:
//   XLEN         address / target width
//   FLUSH_CYCLES extra IF/ID flush cycles after a redirect (0..7)
//   CNT_W        performance counter width
//
// Ports:
//   clk, reset                  rising-edge clock, async active-high reset
//   ex_valid/branch/jump        EX instruction qualifiers
//   ex_pc_sel                   branch condition met
//   ex_target                   resolved control-flow target
//   ex_mem_read, ex_rd          EX load flag and destination register
//   id_valid, id_rs1/2          ID validity and source registers
//   id_use_rs1/2                ID instruction actually reads rs1/rs2
//   dmem_busy                   data memory not ready (freeze)
//   pc_stall, if_id_stall       hold the PC / IF-ID register
//   ex_stall                    hold ID-EX and later stages
//   if_id_flush, id_ex_flush    bubble insertion
//   redirect_valid/_pc          PC redirect request and target
//   misalign_exc                taken target not 4-byte aligned
//   perf_branches, perf_taken   saturating event counters
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_branch,
  input  logic             ex_jump,
  input  logic             ex_pc_sel,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             dmem_busy,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             ex_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             misalign_exc,
  output logic [CNT_W-1:0] perf_branches,
  output logic [CNT_W-1:0] perf_taken
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES);

  state_t           state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0] perf_branches_q, perf_branches_d;
  logic [CNT_W-1:0] perf_taken_q, perf_taken_d;

  logic taken_s;
  logic lu_s;
  logic br_evt_s;
  logic tk_evt_s;

  // Saturating increment used by both performance counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  // Hazard qualifiers.
  // x0 is never a real dependency, so ex_rd==0 cannot cause a load-use stall.
  always_comb begin
    taken_s  = ex_valid & ((ex_branch & ex_pc_sel) | ex_jump);
    lu_s     = ex_valid & ex_mem_read & (ex_rd != 5'd0) & id_valid &
               ((id_use_rs1 & (id_rs1 == ex_rd)) |
                (id_use_rs2 & (id_rs2 == ex_rd)));
    br_evt_s = ex_valid & ex_branch;
    tk_evt_s = ex_valid & ex_branch & ex_pc_sel;
  end

  // Priority decode of control outputs and next flush-sequencer state.
  always_comb begin
    pc_stall       = 1'b0;
    if_id_stall    = 1'b0;
    ex_stall       = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    redirect_valid = 1'b0;
    misalign_exc   = 1'b0;
    state_d        = state_q;
    fcnt_d         = fcnt_q;

    if (dmem_busy) begin
      // Freeze: everything holds, including a pending redirect in EX.
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      ex_stall    = 1'b1;
    end else if (taken_s && !ex_target[1]) begin
      // The ID instruction is wrong-path, so a load-use hit is moot here.
      redirect_valid = 1'b1;
      if_id_flush    = 1'b1;
      id_ex_flush    = 1'b1;
      if (FLUSH_INIT != 3'd0) begin
        state_d = FLUSH;
        fcnt_d  = FLUSH_INIT;
      end else begin
        state_d = RUN;
        fcnt_d  = 3'd0;
      end
    end else if (taken_s) begin
      misalign_exc = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      state_d      = RUN;
      fcnt_d       = 3'd0;
    end else if (lu_s) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
      // Inside a flush window the IF-ID flush still applies.
      // Downstream, flush wins over stall at IF-ID.
      if (state_q == FLUSH) begin
        if_id_flush = 1'b1;
        if (fcnt_q <= 3'd1) begin
          state_d = RUN;
          fcnt_d  = 3'd0;
        end else begin
          fcnt_d = fcnt_q - 3'd1;
        end
      end else begin
        state_d = state_q;
      end
    end else if (state_q == FLUSH) begin
      if_id_flush = 1'b1;
      if (fcnt_q <= 3'd1) begin
        state_d = RUN;
        fcnt_d  = 3'd0;
      end else begin
        fcnt_d = fcnt_q - 3'd1;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Performance counter next values.
  // Counting is gated by the freeze so a stalled branch is counted once.
  always_comb begin
    perf_branches_d = perf_branches_q;
    perf_taken_d    = perf_taken_q;
    if (!dmem_busy) begin
      if (br_evt_s) begin
        perf_branches_d = sat_inc(perf_branches_q);
      end else begin
        perf_branches_d = perf_branches_q;
      end
      if (tk_evt_s) begin
        perf_taken_d = sat_inc(perf_taken_q);
      end else begin
        perf_taken_d = perf_taken_q;
      end
    end else begin
      perf_branches_d = perf_branches_q;
      perf_taken_d    = perf_taken_q;
    end
  end

  // State, flush counter and performance counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= RUN;
      fcnt_q          <= 3'd0;
      perf_branches_q <= '0;
      perf_taken_q    <= '0;
    end else begin
      state_q         <= state_d;
      fcnt_q          <= fcnt_d;
      perf_branches_q <= perf_branches_d;
      perf_taken_q    <= perf_taken_d;
    end
  end

  // Output mapping.
  always_comb begin
    redirect_pc   = ex_target;
    perf_branches = perf_branches_q;
    perf_taken    = perf_taken_q;
  end

  pipeline_hazard_ctrl_checker u_checker (
    .clk            (clk),
    .reset          (reset),
    .dmem_busy      (dmem_busy),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .redirect_valid (redirect_valid),
    .misalign_exc   (misalign_exc)
  );

endmodule

// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_checker
//
// Invariants on the hazard controller outputs.
// Ports: clk, reset, dmem_busy and the flush/redirect/exception outputs.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl_checker (
  input logic clk,
  input logic reset,
  input logic dmem_busy,
  input logic if_id_flush,
  input logic id_ex_flush,
  input logic redirect_valid,
  input logic misalign_exc
);

  a_redir_xor_misalign: assert property (@(posedge clk) disable iff (reset)
    !(redirect_valid && misalign_exc));

  a_freeze_quiet: assert property (@(posedge clk) disable iff (reset)
    dmem_busy |-> (!redirect_valid && !misalign_exc && !if_id_flush && !id_ex_flush));

  a_redirect_flushes: assert property (@(posedge clk) disable iff (reset)
    redirect_valid |-> (if_id_flush && id_ex_flush));

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic        ex_valid, ex_branch, ex_jump, ex_pc_sel;
  logic [31:0] ex_target;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_use_rs1, id_use_rs2;
  logic        dmem_busy;
  logic        pc_stall, if_id_stall, ex_stall, if_id_flush, id_ex_flush;
  logic        redirect_valid, misalign_exc;
  logic [31:0] redirect_pc;
  logic [3:0]  perf_branches, perf_taken;

  int total;
  int bad;

  pipeline_hazard_ctrl #(
    .XLEN         (32),
    .FLUSH_CYCLES (1),
    .CNT_W        (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ex_valid       (ex_valid),
    .ex_branch      (ex_branch),
    .ex_jump        (ex_jump),
    .ex_pc_sel      (ex_pc_sel),
    .ex_target      (ex_target),
    .ex_mem_read    (ex_mem_read),
    .ex_rd          (ex_rd),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .dmem_busy      (dmem_busy),
    .pc_stall       (pc_stall),
    .if_id_stall    (if_id_stall),
    .ex_stall       (ex_stall),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign_exc   (misalign_exc),
    .perf_branches  (perf_branches),
    .perf_taken     (perf_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control bit order: {pc_stall, if_id_stall, ex_stall, if_id_flush,
  //                     id_ex_flush, redirect_valid, misalign_exc}
  typedef struct {
    string       nm;
    logic [6:0]  ctrl;
    logic [31:0] pc;
    logic [3:0]  pb;
    logic [3:0]  pt;
  } exp_t;

  exp_t sb[$];

  task automatic idle();
    ex_valid = 1'b0; ex_branch = 1'b0; ex_jump = 1'b0; ex_pc_sel = 1'b0;
    ex_target = 32'h0; ex_mem_read = 1'b0; ex_rd = 5'd0;
    id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; dmem_busy = 1'b0;
  endtask

  task automatic set_br(input logic v, input logic b, input logic j,
                        input logic s, input logic [31:0] t);
    ex_valid = v; ex_branch = b; ex_jump = j; ex_pc_sel = s; ex_target = t;
  endtask

  task automatic set_ld(input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2);
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_rd = rd; id_valid = 1'b1;
    id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
  endtask

  // Push the expectation for the current input set, then advance one cycle.
  task automatic cyc(input string nm, input logic [6:0] c, input logic [31:0] pc,
                     input logic [3:0] pb, input logic [3:0] pt);
    exp_t e;
    e.nm = nm; e.ctrl = c; e.pc = pc; e.pb = pb; e.pt = pt;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  // Monitor: outputs are presented every cycle; compare at the falling edge.
  initial begin
    exp_t e;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        act = {pc_stall, if_id_stall, ex_stall, if_id_flush, id_ex_flush,
               redirect_valid, misalign_exc};
        total++;
        if (act !== e.ctrl) begin
          bad++;
          $display("FAIL %s ctrl: got %b want %b", e.nm, act, e.ctrl);
        end
        if (e.ctrl[1]) begin
          total++;
          if (redirect_pc !== e.pc) begin
            bad++;
            $display("FAIL %s redirect_pc: got %h want %h", e.nm, redirect_pc, e.pc);
          end
        end
        total++;
        if (perf_branches !== e.pb) begin
          bad++;
          $display("FAIL %s perf_branches: got %0d want %0d", e.nm, perf_branches, e.pb);
        end
        total++;
        if (perf_taken !== e.pt) begin
          bad++;
          $display("FAIL %s perf_taken: got %0d want %0d", e.nm, perf_taken, e.pt);
        end
      end
    end
  end

  initial begin
    int wait_cnt;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    idle();
    @(posedge clk); #1;

    cyc("reset",        7'b0000000, 32'h0, 4'd0, 4'd0);
    reset = 1'b0;
    cyc("idle",         7'b0000000, 32'h0, 4'd0, 4'd0);

    set_br(1'b1, 1'b1, 1'b0, 1'b1, 32'h100);
    cyc("taken",        7'b0001110, 32'h100, 4'd0, 4'd0);
    idle();
    cyc("flush2",       7'b0001000, 32'h0, 4'd1, 4'd1);
    cyc("flush_done",   7'b0000000, 32'h0, 4'd1, 4'd1);

    set_ld(5'd5, 5'd0, 1'b0, 5'd5, 1'b1);
    cyc("lu_rs2",       7'b1100100, 32'h0, 4'd1, 4'd1);
    idle();
    cyc("lu_bubble",    7'b0000000, 32'h0, 4'd1, 4'd1);
    set_ld(5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
    cyc("lu_rd0",       7'b0000000, 32'h0, 4'd1, 4'd1);
    set_ld(5'd7, 5'd7, 1'b1, 5'd3, 1'b0);
    cyc("lu_rs1",       7'b1100100, 32'h0, 4'd1, 4'd1);
    set_ld(5'd7, 5'd7, 1'b0, 5'd3, 1'b1);
    cyc("lu_unused",    7'b0000000, 32'h0, 4'd1, 4'd1);
    idle();

    set_br(1'b1, 1'b0, 1'b1, 1'b0, 32'h102);
    cyc("misalign",     7'b0001101, 32'h0, 4'd1, 4'd1);
    idle();
    cyc("misalign_run", 7'b0000000, 32'h0, 4'd1, 4'd1);

    set_br(1'b1, 1'b1, 1'b0, 1'b1, 32'h200);
    dmem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc("freeze_br",  7'b1110000, 32'h0, 4'd1, 4'd1);
    end
    dmem_busy = 1'b0;
    cyc("deferred",     7'b0001110, 32'h200, 4'd1, 4'd1);
    idle();
    cyc("def_flush",    7'b0001000, 32'h0, 4'd2, 4'd2);
    cyc("def_done",     7'b0000000, 32'h0, 4'd2, 4'd2);

    set_br(1'b1, 1'b1, 1'b0, 1'b1, 32'h300);
    cyc("taken300",     7'b0001110, 32'h300, 4'd2, 4'd2);
    idle();
    dmem_busy = 1'b1;
    cyc("freeze_flush", 7'b1110000, 32'h0, 4'd3, 4'd3);
    dmem_busy = 1'b0;
    cyc("flush_resume", 7'b0001000, 32'h0, 4'd3, 4'd3);
    cyc("resume_done",  7'b0000000, 32'h0, 4'd3, 4'd3);

    set_br(1'b1, 1'b1, 1'b0, 1'b1, 32'h400);
    cyc("taken400",     7'b0001110, 32'h400, 4'd3, 4'd3);
    set_br(1'b1, 1'b1, 1'b0, 1'b1, 32'h404);
    cyc("restart",      7'b0001110, 32'h404, 4'd4, 4'd4);
    idle();
    set_ld(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    cyc("lu_in_flush",  7'b1101100, 32'h0, 4'd5, 4'd5);
    idle();
    cyc("lu_fl_done",   7'b0000000, 32'h0, 4'd5, 4'd5);

    set_br(1'b1, 1'b0, 1'b1, 1'b0, 32'h500);
    cyc("jump",         7'b0001110, 32'h500, 4'd5, 4'd5);
    idle();
    cyc("jump_flush",   7'b0001000, 32'h0, 4'd5, 4'd5);
    set_br(1'b0, 1'b1, 1'b0, 1'b1, 32'h540);
    cyc("invalid_br",   7'b0000000, 32'h0, 4'd5, 4'd5);
    set_br(1'b1, 1'b1, 1'b0, 1'b0, 32'h580);
    cyc("not_taken",    7'b0000000, 32'h0, 4'd5, 4'd5);
    idle();
    cyc("nt_count",     7'b0000000, 32'h0, 4'd6, 4'd5);

    set_br(1'b1, 1'b1, 1'b0, 1'b1, 32'h600);
    cyc("taken600",     7'b0001110, 32'h600, 4'd6, 4'd5);
    idle();
    reset = 1'b1;
    cyc("reset_flush",  7'b0000000, 32'h0, 4'd0, 4'd0);
    reset = 1'b0;
    cyc("post_reset",   7'b0000000, 32'h0, 4'd0, 4'd0);

    set_br(1'b1, 1'b1, 1'b0, 1'b0, 32'h640);
    for (int i = 0; i < 20; i++) begin
      cyc("sat_nt", 7'b0000000, 32'h0, (i > 15) ? 4'd15 : 4'(i), 4'd0);
    end
    set_br(1'b1, 1'b1, 1'b0, 1'b1, 32'h700);
    cyc("sat_taken",    7'b0001110, 32'h700, 4'd15, 4'd0);
    idle();
    cyc("sat_flush",    7'b0001000, 32'h0, 4'd15, 4'd1);
    cyc("sat_done",     7'b0000000, 32'h0, 4'd15, 4'd1);

    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
